// File: rtl/lvg_sequencer.sv
// Command sequencer for the lvg matrix unit: takes one matrix-op command, steps lvg.instr
// through load-L, load-R and a timed mul-class opcode, then streams the 4x4 result back row by row.
module lvg_sequencer #(
  parameter int MUL_CYCLES = 14,
  parameter int ACT_CYCLES = 15,
  parameter int SETTLE     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  output logic         lvg_rst,
  output logic [7:0]   instr,
  input  logic [511:0] lvg_b,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_data,
  output logic [1:0]   res_row,
  output logic         res_last,
  output logic         busy
);

  localparam int CW = $clog2(ACT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_L,
    ST_LOAD_R,
    ST_EXEC,
    ST_SETTLE,
    ST_DRAIN
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     op_q, op_d;
  logic [7:0]     instr_q, instr_d;
  logic [1:0]     row_q, row_d;
  logic [511:0]   cap_q, cap_d;
  logic           lvg_rst_q;
  logic [CW-1:0]  hold_last;
  logic           accept;
  logic [127:0]   cap_rows [4];

  // Activation ops (op[1] set) need one extra cycle for lvg to finish.
  assign hold_last = op_q[1] ? CW'(ACT_CYCLES - 1) : CW'(MUL_CYCLES - 1);
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    row_d   = row_q;
    cap_d   = cap_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = cmd_op;
          state_d = ST_LOAD_L;
        end
      end
      ST_LOAD_L: state_d = ST_LOAD_R;
      ST_LOAD_R: begin
        cnt_d   = '0;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (cnt_q == hold_last) begin
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          cap_d   = lvg_b;
          cnt_d   = '0;
          row_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (res_ready) begin
          if (row_q == 2'd3) begin
            row_d   = '0;
            state_d = ST_IDLE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // instr is registered alongside the state, so it is derived from the next state.
  always_comb begin
    instr_d = 8'd0;
    case (state_d)
      ST_LOAD_L: instr_d = 8'd1;
      ST_LOAD_R: instr_d = 8'd2;
      ST_EXEC:   instr_d = 8'd5 + {6'd0, op_d};
      default:   instr_d = 8'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      instr_q   <= '0;
      row_q     <= '0;
      cap_q     <= '0;
      lvg_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      instr_q   <= instr_d;
      row_q     <= row_d;
      cap_q     <= cap_d;
      lvg_rst_q <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rows
      assign cap_rows[gi] = cap_q[gi*128 +: 128];
    end
  endgenerate

  assign cmd_ready = (state_q == ST_IDLE) && !lvg_rst_q;
  assign lvg_rst   = lvg_rst_q;
  assign instr     = instr_q;
  assign res_valid = (state_q == ST_DRAIN);
  assign res_row   = row_q;
  assign res_data  = cap_rows[row_q];
  assign res_last  = (state_q == ST_DRAIN) && (row_q == 2'd3);
  assign busy      = (state_q != ST_IDLE);

endmodule
